// File: rtl/hangman_pkg.sv
// rtl/hangman_pkg.sv - shared state encoding, defaults and saturating add for the hangman controller
package hangman_pkg;

  typedef enum logic [3:0] {
    LOAD_C     = 4'd0,
    LOAD_GRAPH = 4'd1,
    WAIT_GRAPH = 4'd2,
    GUESS      = 4'd3,
    EVAL       = 4'd4,
    FILL       = 4'd5,
    DRAW       = 4'd6,
    WIN        = 4'd7,
    LOSE       = 4'd8,
    TIMEOUT    = 4'd9
  } state_e;

  localparam int DEF_MAX_WORD   = 16;
  localparam int DEF_MAX_MISSES = 6;

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned lim);
    int unsigned s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/hangman_game_ctrl_if.sv
// rtl/hangman_game_ctrl_if.sv - keyboard, datapath and status signals of the hangman controller
interface hangman_game_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int MAX_WORD    = 16,
  parameter int SCORE_W     = 4
);
  localparam int WL_W = $clog2(MAX_WORD + 1);

  logic                           load, end_input, start, try_guess, wipe;
  logic                           tick, graph_loaded, fill_done, draw_done;
  logic [WL_W-1:0]                match_cnt;
  logic                           wren, ld_char, ld_graph, compare, fill, draw, plot, over;
  logic [3:0]                     part;
  logic [2:0]                     cur_player;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic [WL_W-1:0]                word_len;
  logic                           win, lose, timed_out;

  modport master (
    input  load, end_input, start, try_guess, wipe,
    input  tick, graph_loaded, match_cnt, fill_done, draw_done,
    output wren, ld_char, ld_graph, compare, fill, draw, plot, over,
    output part, cur_player, scores, word_len, win, lose, timed_out
  );

  modport slave (
    output load, end_input, start, try_guess, wipe,
    output tick, graph_loaded, match_cnt, fill_done, draw_done,
    input  wren, ld_char, ld_graph, compare, fill, draw, plot, over,
    input  part, cur_player, scores, word_len, win, lose, timed_out
  );
endinterface

// File: rtl/hangman_key_edge.sv
// rtl/hangman_key_edge.sv - registers keyboard levels and emits one-cycle rising-edge pulses
module hangman_key_edge #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] key_raw,
  output logic [W-1:0] key_rise
);
  logic [W-1:0] sync_q, sync_d, prev_q, prev_d;

  always_comb begin
    sync_d = key_raw;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign key_rise = sync_q & ~prev_q;
endmodule

// File: rtl/hangman_game_ctrl.sv
// rtl/hangman_game_ctrl.sv - multi-player hangman turn controller; HANGMAN_TURN_TIMER_EN adds a per-turn tick timer
module hangman_game_ctrl
  import hangman_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int MAX_WORD    = DEF_MAX_WORD,
  parameter int MAX_MISSES  = DEF_MAX_MISSES,
  parameter int SCORE_W     = 4,
  parameter int TURN_TICKS  = 30
) (
  input logic                clk,
  input logic                resetn,
  hangman_game_ctrl_if.master bus
);
  localparam int WL_W = $clog2(MAX_WORD + 1);
  localparam int SC_W = NUM_PLAYERS * SCORE_W;
  localparam int unsigned SMAX = (1 << SCORE_W) - 1;

  state_e          state_q, state_d;
  logic [WL_W-1:0] word_len_q, word_len_d, remaining_q, remaining_d;
  logic [3:0]      misses_q, misses_d;
  logic [2:0]      cur_player_q, cur_player_d;
  logic [SC_W-1:0] scores_q, scores_d;
  logic            wren_q, wren_d, over_q, over_d;
  logic            ld_graph_q, ld_graph_d, compare_q, compare_d, fill_q, fill_d;
  logic            draw_q, draw_d, plot_q, plot_d, win_q, win_d, lose_q, lose_d;
  logic [4:0]      key;
  int              base;

  hangman_key_edge #(.W(5)) u_key_edge (
    .clk      (clk),
    .resetn   (resetn),
    .key_raw  ({bus.wipe, bus.try_guess, bus.start, bus.end_input, bus.load}),
    .key_rise (key)
  );

`ifdef HANGMAN_TURN_TIMER_EN
  localparam int TM_W = $clog2(TURN_TICKS + 1);
  logic [TM_W-1:0] timer_q, timer_d;
  logic            timed_out_q, timed_out_d;
`endif

  always_comb begin
    state_d      = state_q;
    word_len_d   = word_len_q;
    remaining_d  = remaining_q;
    misses_d     = misses_q;
    cur_player_d = cur_player_q;
    scores_d     = scores_q;
    wren_d       = 1'b0;
    over_d       = 1'b0;
    base         = int'(cur_player_q) * SCORE_W;
`ifdef HANGMAN_TURN_TIMER_EN
    timer_d      = timer_q;
`endif
    case (state_q)
      LOAD_C: begin
        // a load edge consumes the cycle even when the word is already full
        if (key[0]) begin
          if (word_len_q < WL_W'(MAX_WORD)) begin
            wren_d     = 1'b1;
            word_len_d = word_len_q + 1'b1;
          end
        end else if (key[1] && word_len_q != '0) begin
          state_d     = LOAD_GRAPH;
          remaining_d = word_len_q;
        end
      end
      LOAD_GRAPH: if (key[2]) state_d = WAIT_GRAPH;
      WAIT_GRAPH: begin
        if (bus.graph_loaded) begin
          state_d = GUESS;
`ifdef HANGMAN_TURN_TIMER_EN
          timer_d = '0;
`endif
        end
      end
      GUESS: begin
        if (key[3]) state_d = EVAL;
`ifdef HANGMAN_TURN_TIMER_EN
        else if (bus.tick) begin
          timer_d = timer_q + 1'b1;
          if (timer_q == TM_W'(TURN_TICKS - 1)) state_d = TIMEOUT;
        end
`endif
      end
      EVAL: begin
        if (bus.match_cnt != '0) begin
          state_d     = FILL;
          remaining_d = (remaining_q > bus.match_cnt) ? remaining_q - bus.match_cnt : '0;
          scores_d[base +: SCORE_W] = SCORE_W'(sat_add(32'(scores_q[base +: SCORE_W]),
                                                       32'(bus.match_cnt), SMAX));
        end else begin
          state_d      = DRAW;
          misses_d     = misses_q + 4'd1;
          cur_player_d = (cur_player_q == 3'(NUM_PLAYERS - 1)) ? 3'd0 : cur_player_q + 3'd1;
        end
      end
      FILL: begin
        if (bus.fill_done) begin
          state_d = (remaining_q == '0) ? WIN : GUESS;
`ifdef HANGMAN_TURN_TIMER_EN
          timer_d = '0;
`endif
        end
      end
      DRAW: begin
        if (bus.draw_done) begin
          state_d = (misses_q == 4'(MAX_MISSES)) ? LOSE : GUESS;
`ifdef HANGMAN_TURN_TIMER_EN
          timer_d = '0;
`endif
        end
      end
      WIN, LOSE, TIMEOUT: begin
        // scores survive a wipe; only reset clears them
        if (key[4]) begin
          state_d      = LOAD_C;
          over_d       = 1'b1;
          word_len_d   = '0;
          remaining_d  = '0;
          misses_d     = '0;
          cur_player_d = '0;
`ifdef HANGMAN_TURN_TIMER_EN
          timer_d      = '0;
`endif
        end
      end
      default: state_d = LOAD_C;
    endcase

    ld_graph_d = (state_d == LOAD_GRAPH);
    compare_d  = (state_d == EVAL);
    fill_d     = (state_d == FILL);
    draw_d     = (state_d == DRAW);
    win_d      = (state_d == WIN);
    lose_d     = (state_d == LOSE);
    plot_d     = state_d inside {LOAD_GRAPH, FILL, DRAW, WIN, LOSE, TIMEOUT};
`ifdef HANGMAN_TURN_TIMER_EN
    timed_out_d = (state_d == TIMEOUT);
`endif
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q      <= LOAD_C;
      word_len_q   <= '0;
      remaining_q  <= '0;
      misses_q     <= '0;
      cur_player_q <= '0;
      scores_q     <= '0;
      wren_q       <= 1'b0;
      over_q       <= 1'b0;
      ld_graph_q   <= 1'b0;
      compare_q    <= 1'b0;
      fill_q       <= 1'b0;
      draw_q       <= 1'b0;
      plot_q       <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
`ifdef HANGMAN_TURN_TIMER_EN
      timer_q      <= '0;
      timed_out_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      word_len_q   <= word_len_d;
      remaining_q  <= remaining_d;
      misses_q     <= misses_d;
      cur_player_q <= cur_player_d;
      scores_q     <= scores_d;
      wren_q       <= wren_d;
      over_q       <= over_d;
      ld_graph_q   <= ld_graph_d;
      compare_q    <= compare_d;
      fill_q       <= fill_d;
      draw_q       <= draw_d;
      plot_q       <= plot_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
`ifdef HANGMAN_TURN_TIMER_EN
      timer_q      <= timer_d;
      timed_out_q  <= timed_out_d;
`endif
    end
  end

  assign bus.wren       = wren_q;
  assign bus.ld_char    = wren_q;
  assign bus.ld_graph   = ld_graph_q;
  assign bus.compare    = compare_q;
  assign bus.fill       = fill_q;
  assign bus.draw       = draw_q;
  assign bus.plot       = plot_q;
  assign bus.over       = over_q;
  assign bus.part       = misses_q;
  assign bus.cur_player = cur_player_q;
  assign bus.scores     = scores_q;
  assign bus.word_len   = word_len_q;
  assign bus.win        = win_q;
  assign bus.lose       = lose_q;
`ifdef HANGMAN_TURN_TIMER_EN
  assign bus.timed_out  = timed_out_q;
`else
  assign bus.timed_out  = 1'b0;
`endif
endmodule

// File: tb/tb_hangman_game_ctrl.sv
// tb/tb_hangman_game_ctrl.sv - directed self-checking bench for hangman_game_ctrl
module tb_hangman_game_ctrl;
  localparam int NP = 3;
  localparam int MW = 16;
  localparam int SW = 4;
  localparam int K_LOAD = 0, K_END = 1, K_START = 2, K_TRY = 3, K_WIPE = 4;
  localparam int D_GRAPH = 0, D_FILL = 1, D_DRAW = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [4:0] kb = '0;
  logic [2:0] dp = '0;
  logic       tick = 1'b0;
  logic [4:0] match = '0;
  int         errors = 0, checks = 0;
  int         wren_cnt = 0, cmp_cnt = 0, over_cnt = 0;

  hangman_game_ctrl_if #(.NUM_PLAYERS(NP), .MAX_WORD(MW), .SCORE_W(SW)) bus ();

  assign bus.load         = kb[K_LOAD];
  assign bus.end_input    = kb[K_END];
  assign bus.start        = kb[K_START];
  assign bus.try_guess    = kb[K_TRY];
  assign bus.wipe         = kb[K_WIPE];
  assign bus.graph_loaded = dp[D_GRAPH];
  assign bus.fill_done    = dp[D_FILL];
  assign bus.draw_done    = dp[D_DRAW];
  assign bus.tick         = tick;
  assign bus.match_cnt    = match;

  hangman_game_ctrl #(.NUM_PLAYERS(NP), .MAX_WORD(MW), .MAX_MISSES(6), .SCORE_W(SW),
                      .TURN_TICKS(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wren) wren_cnt++;
    if (bus.compare) cmp_cnt++;
    if (bus.over) over_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k);
    kb[k] = 1'b1;
    cyc(3);
    kb[k] = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_dp(input int d);
    dp[d] = 1'b1;
    cyc(1);
    dp[d] = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
  endtask

  task automatic setup_game(input int n);
    for (int i = 0; i < n; i++) press(K_LOAD);
    press(K_END);
    press(K_START);
    pulse_dp(D_GRAPH);
  endtask

  task automatic finish_win();
    match = 5'd16;
    press(K_TRY);
    pulse_dp(D_FILL);
    press(K_WIPE);
  endtask

  task automatic test_reset();
    cyc(2);
    checks++;
    if ({bus.wren, bus.ld_char, bus.ld_graph, bus.compare, bus.fill, bus.draw, bus.plot, bus.over} !== 8'h00) begin
      errors++;
      $display("FAIL reset_enables got=%b exp=00000000",
               {bus.wren, bus.ld_char, bus.ld_graph, bus.compare, bus.fill, bus.draw, bus.plot, bus.over});
    end
    checks++;
    if ({bus.win, bus.lose, bus.timed_out, bus.part, bus.cur_player, bus.word_len, bus.scores} !== '0) begin
      errors++;
      $display("FAIL reset_status got win=%b lose=%b to=%b part=%0d pl=%0d wl=%0d sc=%h exp all 0",
               bus.win, bus.lose, bus.timed_out, bus.part, bus.cur_player, bus.word_len, bus.scores);
    end
    resetn = 1'b0;
    cyc(2);
  endtask

  task automatic test_empty_end();
    press(K_END);
    checks++;
    if (bus.ld_graph !== 1'b0 || bus.plot !== 1'b0) begin
      errors++;
      $display("FAIL empty_end ld_graph=%b plot=%b exp 0 0", bus.ld_graph, bus.plot);
    end
  endtask

  task automatic test_cat_win();
    int w0;
    w0 = wren_cnt;
    for (int i = 0; i < 3; i++) press(K_LOAD);
    checks++;
    if (bus.word_len !== 5'd3 || wren_cnt - w0 != 3) begin
      errors++;
      $display("FAIL cat_load word_len=%0d wren=%0d exp 3 3", bus.word_len, wren_cnt - w0);
    end
    press(K_END);
    checks++;
    if (bus.ld_graph !== 1'b1 || bus.plot !== 1'b1) begin
      errors++;
      $display("FAIL cat_graph ld_graph=%b plot=%b exp 1 1", bus.ld_graph, bus.plot);
    end
    press(K_START);
    pulse_dp(D_GRAPH);
    checks++;
    if (bus.plot !== 1'b0 || bus.ld_graph !== 1'b0) begin
      errors++;
      $display("FAIL cat_guess plot=%b ld_graph=%b exp 0 0", bus.plot, bus.ld_graph);
    end
    w0 = cmp_cnt;
    match = 5'd2;
    press(K_TRY);
    checks++;
    if (bus.fill !== 1'b1 || bus.scores[0 +: SW] !== 4'd2 || cmp_cnt - w0 != 1) begin
      errors++;
      $display("FAIL hit1 fill=%b score0=%0d compares=%0d exp 1 2 1", bus.fill, bus.scores[0 +: SW], cmp_cnt - w0);
    end
    pulse_dp(D_FILL);
    checks++;
    if (bus.fill !== 1'b0 || bus.win !== 1'b0 || bus.cur_player !== 3'd0) begin
      errors++;
      $display("FAIL hit1_back fill=%b win=%b player=%0d exp 0 0 0", bus.fill, bus.win, bus.cur_player);
    end
    match = 5'd1;
    press(K_TRY);
    pulse_dp(D_FILL);
    checks++;
    if (bus.win !== 1'b1 || bus.plot !== 1'b1 || bus.scores[0 +: SW] !== 4'd3) begin
      errors++;
      $display("FAIL win win=%b plot=%b score0=%0d exp 1 1 3", bus.win, bus.plot, bus.scores[0 +: SW]);
    end
    w0 = over_cnt;
    press(K_WIPE);
    checks++;
    if (over_cnt - w0 != 1 || bus.win !== 1'b0 || bus.word_len !== 5'd0 || bus.scores[0 +: SW] !== 4'd3) begin
      errors++;
      $display("FAIL wipe over=%0d win=%b wl=%0d score0=%0d exp 1 0 0 3",
               over_cnt - w0, bus.win, bus.word_len, bus.scores[0 +: SW]);
    end
  endtask

  task automatic test_lose();
    logic [2:0] seq [6];
    seq = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    setup_game(1);
    match = 5'd0;
    for (int i = 0; i < 6; i++) begin
      press(K_TRY);
      checks++;
      if (bus.draw !== 1'b1 || bus.part !== 4'(i + 1) || bus.cur_player !== seq[i]) begin
        errors++;
        $display("FAIL miss%0d draw=%b part=%0d player=%0d exp 1 %0d %0d",
                 i, bus.draw, bus.part, bus.cur_player, i + 1, seq[i]);
      end
      pulse_dp(D_DRAW);
    end
    checks++;
    if (bus.lose !== 1'b1 || bus.plot !== 1'b1 || bus.draw !== 1'b0) begin
      errors++;
      $display("FAIL lose lose=%b plot=%b draw=%b exp 1 1 0", bus.lose, bus.plot, bus.draw);
    end
    press(K_WIPE);
  endtask

  task automatic test_max_word_reset_draw();
    int w0;
    w0 = wren_cnt;
    for (int i = 0; i < 17; i++) press(K_LOAD);
    checks++;
    if (bus.word_len !== 5'd16 || wren_cnt - w0 != 16) begin
      errors++;
      $display("FAIL max_word word_len=%0d wren=%0d exp 16 16", bus.word_len, wren_cnt - w0);
    end
    press(K_END);
    press(K_START);
    pulse_dp(D_GRAPH);
    match = 5'd0;
    press(K_TRY);
    resetn = 1'b1;
    #1;
    checks++;
    if ({bus.draw, bus.plot, bus.lose, bus.part, bus.word_len, bus.scores} !== '0) begin
      errors++;
      $display("FAIL reset_draw draw=%b plot=%b part=%0d wl=%0d sc=%h exp all 0",
               bus.draw, bus.plot, bus.part, bus.word_len, bus.scores);
    end
  endtask

  task automatic test_held_key();
    int c0;
    kb[K_TRY] = 1'b1;
    cyc(1);
    resetn = 1'b0;
    cyc(2);
    c0 = cmp_cnt;
    setup_game(1);
    cyc(4);
    checks++;
    if (cmp_cnt != c0 || bus.plot !== 1'b0 || bus.fill !== 1'b0 || bus.draw !== 1'b0) begin
      errors++;
      $display("FAIL held_try compares=%0d plot=%b exp 0 0", cmp_cnt - c0, bus.plot);
    end
    kb[K_TRY] = 1'b0;
    cyc(2);
    match = 5'd1;
    press(K_TRY);
    checks++;
    if (bus.fill !== 1'b1 || bus.scores[0 +: SW] !== 4'd1) begin
      errors++;
      $display("FAIL repress fill=%b score0=%0d exp 1 1", bus.fill, bus.scores[0 +: SW]);
    end
    pulse_dp(D_FILL);
    checks++;
    if (bus.win !== 1'b1) begin
      errors++;
      $display("FAIL repress_win win=%b exp 1", bus.win);
    end
    press(K_WIPE);
  endtask

`ifdef HANGMAN_TURN_TIMER_EN
  task automatic test_timer();
    setup_game(2);
    pulse_tick();
    pulse_tick();
    checks++;
    if (bus.timed_out !== 1'b0) begin
      errors++;
      $display("FAIL timer_early timed_out=%b exp 0", bus.timed_out);
    end
    pulse_tick();
    checks++;
    if (bus.timed_out !== 1'b1 || bus.plot !== 1'b1) begin
      errors++;
      $display("FAIL timeout timed_out=%b plot=%b exp 1 1", bus.timed_out, bus.plot);
    end
    press(K_WIPE);
    setup_game(2);
    pulse_tick();
    pulse_tick();
    match = 5'd1;
    kb[K_TRY] = 1'b1;
    cyc(1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(2);
    kb[K_TRY] = 1'b0;
    checks++;
    if (bus.fill !== 1'b1 || bus.timed_out !== 1'b0) begin
      errors++;
      $display("FAIL try_beats_tick fill=%b timed_out=%b exp 1 0", bus.fill, bus.timed_out);
    end
    cyc(2);
    pulse_dp(D_FILL);
    finish_win();
  endtask
`else
  task automatic test_no_timer();
    setup_game(1);
    for (int i = 0; i < 5; i++) pulse_tick();
    checks++;
    if (bus.timed_out !== 1'b0 || bus.plot !== 1'b0) begin
      errors++;
      $display("FAIL no_timer timed_out=%b plot=%b exp 0 0", bus.timed_out, bus.plot);
    end
    finish_win();
    checks++;
    if (bus.win !== 1'b0 || bus.word_len !== 5'd0) begin
      errors++;
      $display("FAIL no_timer_end win=%b wl=%0d exp 0 0", bus.win, bus.word_len);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_empty_end();
    test_cat_win();
    test_lose();
    test_max_word_reset_draw();
    test_held_key();
`ifdef HANGMAN_TURN_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
